ysyx_220053_idu: RTL and testbench
==================================

YSYX_220053_IDU -- requirements
Module: ysyx_220053_IDU

Interface
REQ-001 SHALL: clk  input  1  sole clock; all state updates on rising edge.
REQ-002 SHALL: rst  input  1  reset, synchronous, active-high.
REQ-003 SHALL: in_valid  input  1  upstream holds a valid instruction.
REQ-004 SHALL: in_ready  output  1  decoder accepts in_inst/in_pc this cycle.
REQ-005 SHALL: in_inst  input  32  RV64I instruction word.
REQ-006 SHALL: in_pc  input  64  instruction address.
REQ-007 SHALL: flush  input  1  discard held and incoming instruction.
REQ-008 SHALL: out_valid  output  1  decoded bundle valid.
REQ-009 SHALL: out_ready  input  1  downstream (execute/ALU stage) accepts bundle.
REQ-010 SHALL: out_aluop  output  5  ALU operation code.
REQ-011 SHALL: out_srca_pc  output  1  ALU operand A = pc (else rs1 value).
REQ-012 SHALL: out_srcb_imm  output  1  ALU operand B = out_imm (else rs2 value).
REQ-013 SHALL: out_imm  output  64  sign-extended immediate.
REQ-014 SHALL: out_rs1, out_rs2, out_rd  output  5 each  register indices.
REQ-015 SHALL: out_wen  output  1  register write enable (forced 0 when rd = 0).
REQ-016 SHALL: out_illegal  output  1  unsupported encoding.
REQ-017 SHALL: out_pc  output  64  registered copy of in_pc.

Function
REQ-018 SHALL: single output register stage; in_ready = !out_valid | out_ready (combinational); transfer on in_valid & in_ready; latency exactly 1 cycle.
REQ-019 SHALL: while out_valid=1 and out_ready=0, all out_* held stable.
REQ-020 SHALL: out_valid set on input transfer, cleared on output transfer without simultaneous input transfer.
REQ-021 SHALL: simultaneous output and input transfer -> new bundle loaded, out_valid stays 1, no bubble.
REQ-022 SHALL: flush=1 -> out_valid cleared next cycle, incoming instruction dropped; flush has priority over load.
REQ-023 SHALL: ALUOp codes: add 00000, addw 10000, sll 00001, sllw 10001, slt 00010, sltu 00011, xor 00100, srl 00101, srlw 10101, or 00110, and 00111, sub 01000, subw 11000, sra 01101, sraw 11101, passB 01111.
REQ-024 SHALL: OP/OP-IMM map funct3/funct7[5] per REQ-023; funct7[5]=1 selects sub only for OP, sra for SR*; other funct7 values illegal.
REQ-025 SHALL: LUI -> passB, srcb_imm=1; AUIPC -> add, srca_pc=1, srcb_imm=1.
REQ-026 SHALL: LOAD/STORE/JALR -> add, srcb_imm=1; STORE and BRANCH wen=0.
REQ-027 SHALL: BRANCH beq/bne -> sub; blt/bge -> slt; bltu/bgeu -> sltu; srcb_imm=0.
REQ-028 SHALL: JAL -> add, srca_pc=1, srcb_imm=1, imm=J-immediate.
REQ-029 SHALL: 64-bit shift-immediate uses imm[5:0]; W shift with imm[5]=1 illegal.
REQ-030 SHALL: illegal/unknown opcode -> aluop 00000, wen 0, out_illegal 1, bundle still delivered.

Reset
REQ-031 SHALL: on rst, out_valid=0 and every other out_* register = 0 next edge; reset wins over flush and load.
REQ-032 SHALL: rst asserted mid-stall discards held bundle; in_ready=1 the cycle after rst deasserts.

Configuration
REQ-033 SHALL: macro YSYX_220053_IDU_RV64W_EN defined -> OP-32/OP-IMM-32 decoded to W ALUOps; undefined -> those opcodes out_illegal=1, wen=0, aluop 00000.

Verification
REQ-034 SHALL: addi x5,x0,-1 (0xFFF00293), out_ready=1 -> next cycle aluop 00000, imm 0xFFFF_FFFF_FFFF_FFFF, rd 5, wen 1, srcb_imm 1.
REQ-035 SHALL: sraw x1,x2,x3 (0x403150BB) -> aluop 11101 with macro; out_illegal 1, wen 0 without.
REQ-036 SHALL: bltu (0x0020E463) held with out_ready=0 for 3 cycles -> bundle stable, in_ready 0, aluop 00011, wen 0.
REQ-037 SHALL: back-to-back lui/auipc with out_ready=1 -> two consecutive out_valid cycles, aluops 01111 then 00000 with srca_pc 1.
REQ-038 SHALL: flush and in_valid together while stalled -> out_valid 0 next cycle, neither instruction delivered.
REQ-039 SHALL: 0x00000000 -> out_illegal 1, aluop 00000; rst mid-stall -> out_valid 0 next cycle.

Source files
------------

// File: rtl/ysyx_220053_idu.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_220053_idu
// Brief    : RV64I instruction decoder with a single valid/ready output stage.
//            Optional macro YSYX_220053_IDU_RV64W_EN enables OP-32/OP-IMM-32.
// Revision : 1.0
// ============================================================================
module ysyx_220053_idu (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_inst,
    input  logic [63:0] in_pc,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [4:0]  out_aluop,
    output logic        out_srca_pc,
    output logic        out_srcb_imm,
    output logic [63:0] out_imm,
    output logic [4:0]  out_rs1,
    output logic [4:0]  out_rs2,
    output logic [4:0]  out_rd,
    output logic        out_wen,
    output logic        out_illegal,
    output logic [63:0] out_pc
);
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
`ifdef YSYX_220053_IDU_RV64W_EN
    localparam logic [6:0] OPC_OPIMM32 = 7'b0011011;
    localparam logic [6:0] OPC_OP32    = 7'b0111011;
`endif

    localparam logic [4:0] ALU_ADD   = 5'b00000;
    localparam logic [4:0] ALU_SLT   = 5'b00010;
    localparam logic [4:0] ALU_SLTU  = 5'b00011;
    localparam logic [4:0] ALU_SUB   = 5'b01000;
    localparam logic [4:0] ALU_PASSB = 5'b01111;

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rd;
    logic [63:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_sh;

    assign opcode = in_inst[6:0];
    assign funct3 = in_inst[14:12];
    assign funct7 = in_inst[31:25];
    assign rd     = in_inst[11:7];

    assign imm_i  = {{52{in_inst[31]}}, in_inst[31:20]};
    assign imm_s  = {{52{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
    assign imm_b  = {{51{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
    assign imm_u  = {{32{in_inst[31]}}, in_inst[31:12], 12'b0};
    assign imm_j  = {{43{in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0};
    assign imm_sh = {58'd0, in_inst[25:20]};

    logic [4:0]  aluop_d;
    logic        srca_d, srcb_d, wen_d, illegal_d;
    logic [63:0] imm_d;

    // Arithmetic ALU codes are {W, alt, funct3}; illegal words collapse to all-zero controls.
    always_comb begin
        aluop_d   = ALU_ADD;
        srca_d    = 1'b0;
        srcb_d    = 1'b0;
        wen_d     = 1'b0;
        illegal_d = 1'b0;
        imm_d     = '0;
        case (opcode)
            OPC_OP: begin
                wen_d   = 1'b1;
                aluop_d = {1'b0, funct7[5], funct3};
                if (!(funct7 == 7'b0000000 ||
                      (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101))))
                    illegal_d = 1'b1;
            end
            OPC_OPIMM: begin
                wen_d   = 1'b1;
                srcb_d  = 1'b1;
                imm_d   = imm_i;
                aluop_d = {2'b00, funct3};
                if (funct3 == 3'b001 || funct3 == 3'b101) begin
                    imm_d   = imm_sh;
                    aluop_d = {1'b0, in_inst[30], funct3};
                    if (in_inst[31:26] != 6'b000000 &&
                        !(in_inst[31:26] == 6'b010000 && funct3 == 3'b101))
                        illegal_d = 1'b1;
                end
            end
`ifdef YSYX_220053_IDU_RV64W_EN
            OPC_OP32: begin
                wen_d   = 1'b1;
                aluop_d = {1'b1, funct7[5], funct3};
                if (!((funct7 == 7'b0000000 &&
                       (funct3 == 3'b000 || funct3 == 3'b001 || funct3 == 3'b101)) ||
                      (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101))))
                    illegal_d = 1'b1;
            end
            OPC_OPIMM32: begin
                wen_d   = 1'b1;
                srcb_d  = 1'b1;
                imm_d   = imm_i;
                aluop_d = {2'b10, funct3};
                if (funct3 == 3'b001 || funct3 == 3'b101) begin
                    // funct7 covers shamt[5], so a 6-bit shift amount is rejected here.
                    imm_d   = imm_sh;
                    aluop_d = {1'b1, in_inst[30], funct3};
                    if (funct7 != 7'b0000000 && !(funct7 == 7'b0100000 && funct3 == 3'b101))
                        illegal_d = 1'b1;
                end else if (funct3 != 3'b000) begin
                    illegal_d = 1'b1;
                end
            end
`endif
            OPC_LUI: begin
                wen_d   = 1'b1;
                srcb_d  = 1'b1;
                imm_d   = imm_u;
                aluop_d = ALU_PASSB;
            end
            OPC_AUIPC: begin
                wen_d  = 1'b1;
                srca_d = 1'b1;
                srcb_d = 1'b1;
                imm_d  = imm_u;
            end
            OPC_JAL: begin
                wen_d  = 1'b1;
                srca_d = 1'b1;
                srcb_d = 1'b1;
                imm_d  = imm_j;
            end
            OPC_JALR: begin
                wen_d     = 1'b1;
                srcb_d    = 1'b1;
                imm_d     = imm_i;
                illegal_d = (funct3 != 3'b000);
            end
            OPC_LOAD: begin
                wen_d     = 1'b1;
                srcb_d    = 1'b1;
                imm_d     = imm_i;
                illegal_d = (funct3 == 3'b111);
            end
            OPC_STORE: begin
                srcb_d    = 1'b1;
                imm_d     = imm_s;
                illegal_d = funct3[2];
            end
            OPC_BRANCH: begin
                imm_d = imm_b;
                if (funct3[2:1] == 2'b01)
                    illegal_d = 1'b1;
                else if (!funct3[2])
                    aluop_d = ALU_SUB;
                else if (!funct3[1])
                    aluop_d = ALU_SLT;
                else
                    aluop_d = ALU_SLTU;
            end
            default: illegal_d = 1'b1;
        endcase
        wen_d = wen_d & (rd != 5'd0);
        if (illegal_d) begin
            aluop_d = ALU_ADD;
            srca_d  = 1'b0;
            srcb_d  = 1'b0;
            wen_d   = 1'b0;
            imm_d   = '0;
        end
    end

    logic        valid_q, srca_q, srcb_q, wen_q, illegal_q;
    logic [4:0]  aluop_q, rs1_q, rs2_q, rd_q;
    logic [63:0] imm_q, pc_q;
    logic        load;

    assign in_ready = !valid_q | out_ready;
    assign load     = in_valid & in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q   <= 1'b0;
            aluop_q   <= '0;
            srca_q    <= 1'b0;
            srcb_q    <= 1'b0;
            imm_q     <= '0;
            rs1_q     <= '0;
            rs2_q     <= '0;
            rd_q      <= '0;
            wen_q     <= 1'b0;
            illegal_q <= 1'b0;
            pc_q      <= '0;
        end else if (flush) begin
            valid_q <= 1'b0;
        end else if (load) begin
            valid_q   <= 1'b1;
            aluop_q   <= aluop_d;
            srca_q    <= srca_d;
            srcb_q    <= srcb_d;
            imm_q     <= imm_d;
            rs1_q     <= in_inst[19:15];
            rs2_q     <= in_inst[24:20];
            rd_q      <= rd;
            wen_q     <= wen_d;
            illegal_q <= illegal_d;
            pc_q      <= in_pc;
        end else if (out_ready) begin
            valid_q <= 1'b0;
        end
    end

    assign out_valid    = valid_q;
    assign out_aluop    = aluop_q;
    assign out_srca_pc  = srca_q;
    assign out_srcb_imm = srcb_q;
    assign out_imm      = imm_q;
    assign out_rs1      = rs1_q;
    assign out_rs2      = rs2_q;
    assign out_rd       = rd_q;
    assign out_wen      = wen_q;
    assign out_illegal  = illegal_q;
    assign out_pc       = pc_q;
endmodule
`default_nettype wire

// File: tb/tb_ysyx_220053_idu.sv
`default_nettype none
// ============================================================================
// Module   : tb_ysyx_220053_idu
// Brief    : Directed and randomized bench for ysyx_220053_idu, encoding
//            instructions from mnemonics and scoreboarding delivered bundles.
// Revision : 1.0
// ============================================================================
module tb_ysyx_220053_idu;
    localparam logic [4:0] ALU_ADD  = 5'b00000, ALU_ADDW = 5'b10000, ALU_SLL  = 5'b00001;
    localparam logic [4:0] ALU_SLLW = 5'b10001, ALU_SLT  = 5'b00010, ALU_SLTU = 5'b00011;
    localparam logic [4:0] ALU_XOR  = 5'b00100, ALU_SRL  = 5'b00101, ALU_SRLW = 5'b10101;
    localparam logic [4:0] ALU_OR   = 5'b00110, ALU_AND  = 5'b00111, ALU_SUB  = 5'b01000;
    localparam logic [4:0] ALU_SUBW = 5'b11000, ALU_SRA  = 5'b01101, ALU_SRAW = 5'b11101;
    localparam logic [4:0] ALU_PASSB = 5'b01111;
`ifdef YSYX_220053_IDU_RV64W_EN
    localparam bit W_EN = 1'b1;
`else
    localparam bit W_EN = 1'b0;
`endif

    logic        clk, rst, in_valid, in_ready, flush, out_valid, out_ready;
    logic [31:0] in_inst;
    logic [63:0] in_pc, out_imm, out_pc;
    logic [4:0]  out_aluop, out_rs1, out_rs2, out_rd;
    logic        out_srca_pc, out_srcb_imm, out_wen, out_illegal;

    ysyx_220053_idu dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_inst(in_inst), .in_pc(in_pc), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .out_aluop(out_aluop), .out_srca_pc(out_srca_pc),
        .out_srcb_imm(out_srcb_imm), .out_imm(out_imm), .out_rs1(out_rs1),
        .out_rs2(out_rs2), .out_rd(out_rd), .out_wen(out_wen),
        .out_illegal(out_illegal), .out_pc(out_pc)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0]  aluop;
        logic        srca;
        logic        srcb;
        logic [63:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        wen;
        logic        ill;
        logic [63:0] pc;
    } bundle_t;

    bundle_t q[$];
    int n_checks = 0;
    int n_err    = 0;

    function automatic bundle_t cur_obs();
        return {out_aluop, out_srca_pc, out_srcb_imm, out_imm, out_rs1, out_rs2,
                out_rd, out_wen, out_illegal, out_pc};
    endfunction

    // Expected bundle: register fields are the raw instruction slices; rd=0 never writes.
    function automatic bundle_t mk(input logic [4:0] alu, input logic sa, input logic sb,
                                   input logic [63:0] imm, input logic [31:0] w,
                                   input logic writes, input logic ill);
        bundle_t b;
        b.aluop = alu;
        b.srca  = sa;
        b.srcb  = sb;
        b.imm   = imm;
        b.rs1   = w[19:15];
        b.rs2   = w[24:20];
        b.rd    = w[11:7];
        b.wen   = writes && (w[11:7] != 5'd0);
        b.ill   = ill;
        b.pc    = '0;
        return b;
    endfunction

    task automatic chk(input string tag, input logic [151:0] o, input logic [151:0] e);
        n_checks++;
        assert (o === e) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    task automatic cycle(input logic v, input logic [31:0] w, input logic [63:0] pc,
                         input bundle_t e, input logic ordy, input logic fl);
        bundle_t eb;
        logic    pop, acc;
        @(negedge clk);
        in_valid = v; in_inst = w; in_pc = pc; out_ready = ordy; flush = fl;
        #1;
        chk("out_valid", out_valid, q.size() != 0);
        chk("in_ready", in_ready, (q.size() == 0) || ordy);
        if (q.size() != 0) chk("bundle", cur_obs(), q[0]);
        pop = (q.size() != 0) && ordy;
        acc = v && ((q.size() == 0) || ordy) && !fl;
        eb = e;
        eb.pc = pc;
        @(posedge clk);
        if (fl) q.delete();
        else begin
            if (pop) void'(q.pop_front());
            if (acc) q.push_back(eb);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1; in_valid = 1; in_inst = 32'hFFF00293; in_pc = 64'h1234; out_ready = 0; flush = 0;
        @(posedge clk);
        q.delete();
        #1;
        chk("rst_valid", out_valid, 0);
        chk("rst_bundle", cur_obs(), 0);
        chk("rst_in_ready", in_ready, 1);
        @(negedge clk);
        rst = 0; in_valid = 0;
    endtask

    task automatic gen_rand(output logic [31:0] w, output bundle_t e);
        logic [4:0]  rd, rs1, rs2, alu;
        logic [2:0]  f3;
        logic        alt;
        logic [5:0]  hi;
        logic [31:0] t;
        logic [19:0] u;
        int          v, sh, m;
        rd  = 5'($urandom); rs1 = 5'($urandom); rs2 = 5'($urandom);
        v   = int'($urandom_range(0, 4095)) - 2048;
        t   = 32'(v);
        f3 = 3'd0; alt = 1'b0; alu = ALU_ADD; hi = 6'd0;
        m   = int'($urandom_range(0, 9));
        case ($urandom_range(0, 12))
            0: begin
                case (m)
                    0: begin f3 = 3'd0; alu = ALU_ADD;  end
                    1: begin f3 = 3'd0; alt = 1'b1; alu = ALU_SUB; end
                    2: begin f3 = 3'd1; alu = ALU_SLL;  end
                    3: begin f3 = 3'd2; alu = ALU_SLT;  end
                    4: begin f3 = 3'd3; alu = ALU_SLTU; end
                    5: begin f3 = 3'd4; alu = ALU_XOR;  end
                    6: begin f3 = 3'd5; alu = ALU_SRL;  end
                    7: begin f3 = 3'd5; alt = 1'b1; alu = ALU_SRA; end
                    8: begin f3 = 3'd6; alu = ALU_OR;   end
                    default: begin f3 = 3'd7; alu = ALU_AND; end
                endcase
                w = {1'b0, alt, 5'b0, rs2, rs1, f3, rd, 7'b0110011};
                e = mk(alu, 0, 0, 64'd0, w, 1, 0);
            end
            1: begin
                case (m % 6)
                    0: begin f3 = 3'd0; alu = ALU_ADD;  end
                    1: begin f3 = 3'd2; alu = ALU_SLT;  end
                    2: begin f3 = 3'd3; alu = ALU_SLTU; end
                    3: begin f3 = 3'd4; alu = ALU_XOR;  end
                    4: begin f3 = 3'd6; alu = ALU_OR;   end
                    default: begin f3 = 3'd7; alu = ALU_AND; end
                endcase
                w = {t[11:0], rs1, f3, rd, 7'b0010011};
                e = mk(alu, 0, 1, 64'(longint'(v)), w, 1, 0);
            end
            2: begin
                sh = int'($urandom_range(0, 63));
                t  = 32'(sh);
                case (m % 3)
                    0: begin f3 = 3'd1; alu = ALU_SLL; end
                    1: begin f3 = 3'd5; alu = ALU_SRL; end
                    default: begin f3 = 3'd5; hi = 6'b010000; alu = ALU_SRA; end
                endcase
                w = {hi, t[5:0], rs1, f3, rd, 7'b0010011};
                e = mk(alu, 0, 1, 64'(sh), w, 1, 0);
            end
            3, 4: begin
                u = 20'($urandom);
                t = {u, 12'h000};
                v = int'(t);
                if (m < 5) begin
                    w = {u, rd, 7'b0110111};
                    e = mk(ALU_PASSB, 0, 1, 64'(longint'(v)), w, 1, 0);
                end else begin
                    w = {u, rd, 7'b0010111};
                    e = mk(ALU_ADD, 1, 1, 64'(longint'(v)), w, 1, 0);
                end
            end
            5: begin
                v = int'($urandom_range(0, 1048575)) * 2 - 1048576;
                t = 32'(v);
                w = {t[20], t[10:1], t[11], t[19:12], rd, 7'b1101111};
                e = mk(ALU_ADD, 1, 1, 64'(longint'(v)), w, 1, 0);
            end
            6: begin
                w = {t[11:0], rs1, 3'b000, rd, 7'b1100111};
                e = mk(ALU_ADD, 0, 1, 64'(longint'(v)), w, 1, 0);
            end
            7: begin
                f3 = 3'($urandom_range(0, 6));
                w  = {t[11:0], rs1, f3, rd, 7'b0000011};
                e  = mk(ALU_ADD, 0, 1, 64'(longint'(v)), w, 1, 0);
            end
            8: begin
                f3 = 3'($urandom_range(0, 3));
                w  = {t[11:5], rs2, rs1, f3, t[4:0], 7'b0100011};
                e  = mk(ALU_ADD, 0, 1, 64'(longint'(v)), w, 0, 0);
            end
            9: begin
                v = int'($urandom_range(0, 4095)) * 2 - 4096;
                t = 32'(v);
                case (m % 6)
                    0: begin f3 = 3'd0; alu = ALU_SUB;  end
                    1: begin f3 = 3'd1; alu = ALU_SUB;  end
                    2: begin f3 = 3'd4; alu = ALU_SLT;  end
                    3: begin f3 = 3'd5; alu = ALU_SLT;  end
                    4: begin f3 = 3'd6; alu = ALU_SLTU; end
                    default: begin f3 = 3'd7; alu = ALU_SLTU; end
                endcase
                w = {t[12], t[10:5], rs2, rs1, f3, t[4:1], t[11], 7'b1100011};
                e = mk(alu, 0, 0, 64'(longint'(v)), w, 0, 0);
            end
            10: begin
                case (m % 5)
                    0: begin f3 = 3'd0; alu = ALU_ADDW; end
                    1: begin f3 = 3'd0; alt = 1'b1; alu = ALU_SUBW; end
                    2: begin f3 = 3'd1; alu = ALU_SLLW; end
                    3: begin f3 = 3'd5; alu = ALU_SRLW; end
                    default: begin f3 = 3'd5; alt = 1'b1; alu = ALU_SRAW; end
                endcase
                w = {1'b0, alt, 5'b0, rs2, rs1, f3, rd, 7'b0111011};
                if (W_EN) e = mk(alu, 0, 0, 64'd0, w, 1, 0);
                else      e = mk(ALU_ADD, 0, 0, 64'd0, w, 0, 1);
            end
            11: begin
                sh = int'($urandom_range(0, 31));
                case (m % 4)
                    0: begin f3 = 3'd0; alu = ALU_ADDW; end
                    1: begin f3 = 3'd1; alu = ALU_SLLW; t = 32'(sh); end
                    2: begin f3 = 3'd5; alu = ALU_SRLW; t = 32'(sh); end
                    default: begin f3 = 3'd5; alt = 1'b1; alu = ALU_SRAW; t = 32'(sh); end
                endcase
                if (f3 == 3'd0) w = {t[11:0], rs1, f3, rd, 7'b0011011};
                else            w = {1'b0, alt, 5'b0, t[4:0], rs1, f3, rd, 7'b0011011};
                if (!W_EN)           e = mk(ALU_ADD, 0, 0, 64'd0, w, 0, 1);
                else if (f3 == 3'd0) e = mk(alu, 0, 1, 64'(longint'(v)), w, 1, 0);
                else                 e = mk(alu, 0, 1, 64'(sh), w, 1, 0);
            end
            default: begin
                case (m % 5)
                    0: w = 32'h0000000F;
                    1: w = {7'b0000001, rs2, rs1, 3'($urandom), rd, 7'b0110011};
                    2: w = {6'b100000, t[5:0], rs1, 3'b101, rd, 7'b0010011};
                    3: w = {6'b000000, 1'b1, t[4:0], rs1, 3'b001, rd, 7'b0011011};
                    default: w = {7'b0100000, rs2, rs1, 3'b100, rd, 7'b0110011};
                endcase
                e = mk(ALU_ADD, 0, 0, 64'd0, w, 0, 1);
            end
        endcase
    endtask

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        bundle_t     e, nil;
        logic [31:0] w;
        logic [63:0] pc;
        nil = '0;
        clk = 0; rst = 1; in_valid = 0; in_inst = 0; in_pc = 0; flush = 0; out_ready = 0;

        do_reset();

        // addi x5,x0,-1
        w = 32'hFFF00293; pc = 64'h0000_0000_8000_0000;
        cycle(1, w, pc, mk(ALU_ADD, 0, 1, 64'hFFFF_FFFF_FFFF_FFFF, w, 1, 0), 1, 0);
        #1;
        chk("addi_valid", out_valid, 1);
        chk("addi_aluop", out_aluop, 5'b00000);
        chk("addi_imm", out_imm, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("addi_rd", out_rd, 5'd5);
        chk("addi_wen", out_wen, 1);
        chk("addi_srcb", out_srcb_imm, 1);

        // sraw x1,x2,x3
        w = 32'h403150BB;
        if (W_EN) e = mk(ALU_SRAW, 0, 0, 64'd0, w, 1, 0);
        else      e = mk(ALU_ADD, 0, 0, 64'd0, w, 0, 1);
        cycle(1, w, pc + 4, e, 1, 0);
        #1;
        chk("sraw_aluop", out_aluop, W_EN ? 5'b11101 : 5'b00000);
        chk("sraw_ill", out_illegal, W_EN ? 1'b0 : 1'b1);
        chk("sraw_wen", out_wen, W_EN ? 1'b1 : 1'b0);
        cycle(0, 32'h0, 64'h0, nil, 1, 0);

        // bltu held for three stalled cycles
        w = 32'h0020E463;
        cycle(1, w, pc + 8, mk(ALU_SLTU, 0, 0, 64'd8, w, 0, 0), 0, 0);
        for (int i = 0; i < 3; i++) begin
            cycle(1, 32'h00000013, pc + 12, mk(ALU_ADD, 0, 1, 64'd0, 32'h00000013, 1, 0), 0, 0);
            #1;
            chk("bltu_in_ready", in_ready, 0);
            chk("bltu_valid", out_valid, 1);
            chk("bltu_aluop", out_aluop, 5'b00011);
            chk("bltu_wen", out_wen, 0);
        end
        cycle(0, 32'h0, 64'h0, nil, 1, 0);
        cycle(0, 32'h0, 64'h0, nil, 1, 0);

        // lui then auipc back to back
        w = 32'h123450B7;
        cycle(1, w, pc + 16, mk(ALU_PASSB, 0, 1, 64'h12345000, w, 1, 0), 1, 0);
        #1;
        chk("lui_valid", out_valid, 1);
        chk("lui_aluop", out_aluop, 5'b01111);
        w = 32'h00001117;
        cycle(1, w, pc + 20, mk(ALU_ADD, 1, 1, 64'h1000, w, 1, 0), 1, 0);
        #1;
        chk("auipc_valid", out_valid, 1);
        chk("auipc_aluop", out_aluop, 5'b00000);
        chk("auipc_srca", out_srca_pc, 1);
        cycle(0, 32'h0, 64'h0, nil, 1, 0);

        // flush with a new instruction while stalled
        w = 32'hFFF00293;
        cycle(1, w, pc + 24, mk(ALU_ADD, 0, 1, 64'hFFFF_FFFF_FFFF_FFFF, w, 1, 0), 0, 0);
        w = 32'h123450B7;
        cycle(1, w, pc + 28, mk(ALU_PASSB, 0, 1, 64'h12345000, w, 1, 0), 0, 1);
        #1;
        chk("flush_valid", out_valid, 0);
        cycle(0, 32'h0, 64'h0, nil, 1, 0);

        // all-zero word, then reset while stalled
        cycle(1, 32'h0, pc + 32, mk(ALU_ADD, 0, 0, 64'd0, 32'h0, 0, 1), 0, 0);
        #1;
        chk("zero_ill", out_illegal, 1);
        chk("zero_aluop", out_aluop, 5'b00000);
        chk("zero_valid", out_valid, 1);
        do_reset();
        cycle(0, 32'h0, 64'h0, nil, 0, 0);

        for (int n = 0; n < 800; n++) begin
            if ($urandom_range(0, 99) == 0) begin
                do_reset();
            end else begin
                gen_rand(w, e);
                cycle($urandom_range(0, 3) != 0, w, {$urandom, $urandom}, e,
                      $urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0);
            end
        end
        cycle(0, 32'h0, 64'h0, nil, 1, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end
endmodule
`default_nettype wire
